// File: rtl/ex_mc.sv
// Execute stage: single-cycle logic/shift/arith/move ops, a radix-2 restoring divider FSM
// and the architectural HI/LO registers. Define EX_MC_MULT_EN to add MULT/MULTU.
module ex_mc #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            alu_sel_i,
  input  logic [7:0]            alu_op_i,
  input  logic [DATA_W-1:0]     op_number_1_i,
  input  logic [DATA_W-1:0]     op_number_2_i,
  input  logic                  write_reg_en_i,
  input  logic [REG_ADDR_W-1:0] write_reg_addr_i,
  input  logic                  flush_i,
  output logic                  write_reg_en_o,
  output logic [REG_ADDR_W-1:0] write_reg_addr_o,
  output logic [DATA_W-1:0]     write_reg_data_o,
  output logic                  stall_req_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int CNT_W   = $clog2(DATA_W + 1);

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
`ifdef EX_MC_MULT_EN
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DZERO, S_RUN, S_DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     w_stall;
  logic [CNT_W-1:0]         r_cnt;
  logic [DATA_W-1:0]        r_quo, r_rem, r_dvs;
  logic                     r_neg_q, r_neg_r;
  logic [DATA_W-1:0]        r_hi, r_lo;
  logic [DATA_W-1:0]        w_result;
  logic signed [DATA_W-1:0] w_op1_s, w_op2_s;
  logic [SHAMT_W-1:0]       w_shamt;
  logic                     w_is_div, w_div_signed, w_div_start, w_op2_zero;
  logic                     w_op1_neg, w_op2_neg;
  logic [DATA_W-1:0]        w_mag1, w_mag2;
  logic [DATA_W:0]          w_rem_sh, w_trial;
`ifdef EX_MC_MULT_EN
  logic signed [2*DATA_W-1:0] w_prod_s;
  logic [2*DATA_W-1:0]        w_prod_u;
`endif

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign w_op1_s      = op_number_1_i;
  assign w_op2_s      = op_number_2_i;
  assign w_shamt      = op_number_1_i[SHAMT_W-1:0];
  assign w_is_div     = (alu_op_i == OP_DIV) || (alu_op_i == OP_DIVU);
  assign w_div_signed = (alu_op_i == OP_DIV);
  assign w_div_start  = (r_state == S_IDLE) && w_is_div && !flush_i;
  assign w_op2_zero   = (op_number_2_i == '0);
  assign w_op1_neg    = w_div_signed && op_number_1_i[DATA_W-1];
  assign w_op2_neg    = w_div_signed && op_number_2_i[DATA_W-1];
  assign w_mag1       = apply_sign(op_number_1_i, w_op1_neg);
  assign w_mag2       = apply_sign(op_number_2_i, w_op2_neg);

  // Restoring step: a non-negative trial (MSB clear) means the divisor fits.
  assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_dvs};

`ifdef EX_MC_MULT_EN
  assign w_prod_s = (2*DATA_W)'(w_op1_s) * (2*DATA_W)'(w_op2_s);
  assign w_prod_u = (2*DATA_W)'(op_number_1_i) * (2*DATA_W)'(op_number_2_i);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div) begin
            w_stall     = 1'b1;
            w_state_nxt = w_op2_zero ? S_DZERO : S_RUN;
          end
        end
        S_DZERO: begin
          w_stall     = 1'b1;
          w_state_nxt = S_DONE;
        end
        S_RUN: begin
          w_stall = 1'b1;
          if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = S_DONE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_result = '0;
    case (alu_sel_i)
      SEL_LOGIC: begin
        case (alu_op_i)
          OP_OR:   w_result = op_number_1_i | op_number_2_i;
          OP_AND:  w_result = op_number_1_i & op_number_2_i;
          OP_XOR:  w_result = op_number_1_i ^ op_number_2_i;
          OP_NOR:  w_result = ~(op_number_1_i | op_number_2_i);
          default: w_result = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (alu_op_i)
          OP_SLL:  w_result = op_number_2_i << w_shamt;
          OP_SRL:  w_result = op_number_2_i >> w_shamt;
          OP_SRA:  w_result = w_op2_s >>> w_shamt;
          default: w_result = '0;
        endcase
      end
      SEL_MOVE: begin
        case (alu_op_i)
          OP_MFHI: w_result = r_hi;
          OP_MFLO: w_result = r_lo;
          default: w_result = '0;
        endcase
      end
      SEL_ARITH: begin
        case (alu_op_i)
          OP_ADDU: w_result = op_number_1_i + op_number_2_i;
          OP_SUBU: w_result = op_number_1_i - op_number_2_i;
          OP_SLT:  w_result = {{(DATA_W-1){1'b0}}, (w_op1_s < w_op2_s)};
          OP_SLTU: w_result = {{(DATA_W-1){1'b0}}, (op_number_1_i < op_number_2_i)};
          default: w_result = '0;
        endcase
      end
      default: w_result = '0;
    endcase
  end

  // Control: FSM state, step counter and the architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_div_start) r_cnt <= '0;
      else if (r_state == S_RUN) r_cnt <= r_cnt + CNT_W'(1);
      if ((r_state == S_DONE) && !flush_i) begin
        r_lo <= apply_sign(r_quo, r_neg_q);
        r_hi <= apply_sign(r_rem, r_neg_r);
      end else if (!w_stall) begin
        if (alu_op_i == OP_MTHI) r_hi <= op_number_1_i;
        if (alu_op_i == OP_MTLO) r_lo <= op_number_1_i;
`ifdef EX_MC_MULT_EN
        if (alu_op_i == OP_MULT) begin
          r_hi <= w_prod_s[2*DATA_W-1:DATA_W];
          r_lo <= w_prod_s[DATA_W-1:0];
        end
        if (alu_op_i == OP_MULTU) begin
          r_hi <= w_prod_u[2*DATA_W-1:DATA_W];
          r_lo <= w_prod_u[DATA_W-1:0];
        end
`endif
      end
    end
  end

  // Divider datapath; divide-by-zero preloads the final result and skips quotient fix-up.
  always_ff @(posedge clk) begin
    if (w_div_start) begin
      r_dvs   <= w_mag2;
      r_neg_r <= w_op1_neg;
      if (w_op2_zero) begin
        r_quo   <= '1;
        r_rem   <= w_mag1;
        r_neg_q <= 1'b0;
      end else begin
        r_quo   <= w_mag1;
        r_rem   <= '0;
        r_neg_q <= w_op1_neg ^ w_op2_neg;
      end
    end else if (r_state == S_RUN) begin
      r_quo <= {r_quo[DATA_W-2:0], ~w_trial[DATA_W]};
      r_rem <= w_trial[DATA_W] ? w_rem_sh[DATA_W-1:0] : w_trial[DATA_W-1:0];
    end
  end

  assign write_reg_en_o   = rst ? 1'b0 : write_reg_en_i;
  assign write_reg_addr_o = rst ? '0 : write_reg_addr_i;
  assign write_reg_data_o = rst ? '0 : w_result;
  assign stall_req_o      = w_stall && !rst;
  assign hi_o             = r_hi;
  assign lo_o             = r_lo;

endmodule

// File: tb/tb_ex_mc.sv
// Randomized self-checking bench for ex_mc against a behavioural HI/LO and result model.
module tb_ex_mc;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    alu_sel_i;
  logic [7:0]    alu_op_i;
  logic [DW-1:0] op1, op2;
  logic          we_i;
  logic [AW-1:0] wa_i;
  logic          flush_i;
  logic          we_o;
  logic [AW-1:0] wa_o;
  logic [DW-1:0] wd_o;
  logic          stall_o;
  logic [DW-1:0] hi_o, lo_o;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] m_hi = '0;
  logic [DW-1:0] m_lo = '0;

  ex_mc #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .alu_sel_i(alu_sel_i), .alu_op_i(alu_op_i),
    .op_number_1_i(op1), .op_number_2_i(op2),
    .write_reg_en_i(we_i), .write_reg_addr_i(wa_i), .flush_i(flush_i),
    .write_reg_en_o(we_o), .write_reg_addr_o(wa_o), .write_reg_data_o(wd_o),
    .stall_req_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_result(input logic [2:0] sel, input logic [7:0] op,
                                               input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    int sh;
    longint sb;
    sh = int'(a % 32);
    sb = longint'($signed(b));
    case (sel)
      3'b001: case (op)
        8'h25: return a | b;
        8'h24: return a & b;
        8'h26: return a ^ b;
        8'h27: return ~(a | b);
        default: return '0;
      endcase
      3'b010: case (op)
        8'h7C: return DW'(longint'(b) * (64'd1 << sh));
        8'h02: return DW'(longint'(b) / (64'd1 << sh));
        8'h03: return DW'(sb >>> sh);
        default: return '0;
      endcase
      3'b011: case (op)
        8'h10: return hi;
        8'h12: return lo;
        default: return '0;
      endcase
      3'b100: case (op)
        8'h21: return DW'(longint'(a) + longint'(b));
        8'h23: return DW'(longint'(a) - longint'(b));
        8'h2A: return (longint'($signed(a)) < sb) ? 1 : 0;
        8'h2B: return (longint'(a) < longint'(b)) ? 1 : 0;
        default: return '0;
      endcase
      default: return '0;
    endcase
  endfunction

  task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    alu_sel_i = sel;
    alu_op_i  = op;
    op1       = a;
    op2       = b;
    we_i      = 1'($urandom);
    wa_i      = AW'($urandom);
  endtask

  // One single-cycle op: check result now, HI/LO after the edge.
  task automatic single(input string tag, input logic [2:0] sel, input logic [7:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] exp_r;
    drive(sel, op, a, b);
    #1;
    exp_r = ref_result(sel, op, a, b, m_hi, m_lo);
    chk({tag, " result"}, wd_o, exp_r);
    chk({tag, " we"}, we_o, we_i);
    chk({tag, " addr"}, wa_o, wa_i);
    chk({tag, " stall"}, stall_o, 1'b0);
    if (op == 8'h11) m_hi = a;
    if (op == 8'h13) m_lo = a;
`ifdef EX_MC_MULT_EN
    if (op == 8'h18) begin
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      m_hi = p[63:32];
      m_lo = p[31:0];
    end
    if (op == 8'h19) begin
      logic [63:0] pu;
      pu = {32'd0, a} * {32'd0, b};
      m_hi = pu[63:32];
      m_lo = pu[31:0];
    end
`endif
    @(posedge clk); #1;
    chk({tag, " hi"}, hi_o, m_hi);
    chk({tag, " lo"}, lo_o, m_lo);
  endtask

  // Divide: counts stall cycles; flush_at >= 0 aborts on that stall cycle.
  task automatic div_op(input string tag, input bit sgn, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input int flush_at);
    int cnt;
    bit flushed;
    logic [DW-1:0] q, r;
    cnt = 0;
    flushed = 0;
    drive(3'b100, sgn ? 8'h1A : 8'h1B, a, b);
    #1;
    chk({tag, " data"}, wd_o, '0);
    while (stall_o === 1'b1 && cnt < 100) begin
      if (cnt == flush_at) begin
        flush_i = 1'b1;
        #1;
        chk({tag, " flush stall"}, stall_o, 1'b0);
        flushed = 1;
        break;
      end
      cnt++;
      @(posedge clk); #1;
    end
    if (flushed) begin
      @(posedge clk); #1;
      flush_i = 1'b0;
      drive(3'b000, 8'h00, '0, '0);
      #1;
      chk({tag, " flush stall after"}, stall_o, 1'b0);
      chk({tag, " flush hi"}, hi_o, m_hi);
      chk({tag, " flush lo"}, lo_o, m_lo);
      return;
    end
    chk({tag, " stall cycles"}, cnt, (b == 0) ? 2 : DW + 1);
    chk({tag, " done hi held"}, hi_o, m_hi);
    chk({tag, " done data"}, wd_o, '0);
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      longint sa, sbv;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      q = DW'(sa / sbv);
      r = DW'(sa % sbv);
    end else begin
      q = a / b;
      r = a % b;
    end
    m_lo = q;
    m_hi = r;
    drive(3'b000, 8'h00, '0, '0);
    @(posedge clk); #1;
    chk({tag, " hi"}, hi_o, m_hi);
    chk({tag, " lo"}, lo_o, m_lo);
  endtask

  logic [7:0] ops  [20] = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'h21, 8'h23,
                            8'h2A, 8'h2B, 8'h10, 8'h11, 8'h12, 8'h13, 8'h1A, 8'h1B, 8'h18,
                            8'h19, 8'hFF};
  logic [2:0] sels [20] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4, 3'd4,
                            3'd4, 3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4,
                            3'd4, 3'd1};

  initial begin
    int k;
    logic [DW-1:0] a, b;
    logic [2:0] s;
    rst = 1'b1;
    flush_i = 1'b0;
    alu_sel_i = 3'b001;
    alu_op_i = 8'h25;
    op1 = 32'h1234_5678;
    op2 = 32'h0F0F_0F0F;
    we_i = 1'b1;
    wa_i = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    chk("rst data", wd_o, '0);
    chk("rst we", we_o, 1'b0);
    chk("rst addr", wa_o, '0);
    chk("rst stall", stall_o, 1'b0);
    chk("rst hi", hi_o, '0);
    chk("rst lo", lo_o, '0);
    rst = 1'b0;

    single("or", 3'b001, 8'h25, 32'hF0F0_0000, 32'h0000_0F0F);
    chk("or const", ref_result(3'b001, 8'h25, 32'hF0F0_0000, 32'h0000_0F0F, '0, '0), 32'hF0F0_0F0F);
    single("sra", 3'b010, 8'h03, 32'd4, 32'h8000_0000);
    single("slt", 3'b100, 8'h2A, 32'hFFFF_FFFF, 32'd1);
    single("mthi", 3'b011, 8'h11, 32'h0000_1234, 32'd0);
    single("mfhi", 3'b011, 8'h10, 32'd0, 32'd0);
    chk("mfhi value", m_hi, 32'h0000_1234);
    single("mtlo", 3'b011, 8'h13, 32'hCAFE_0001, 32'd0);
    div_op("divu 100/7", 1'b0, 32'd100, 32'd7, -1);
    chk("divu 100/7 lo const", lo_o, 32'h0000_000E);
    chk("divu 100/7 hi const", hi_o, 32'h0000_0002);
    div_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
    chk("div -7/2 lo const", lo_o, 32'hFFFF_FFFD);
    div_op("divu 5/0", 1'b0, 32'd5, 32'd0, -1);
    chk("divu 5/0 lo const", lo_o, 32'hFFFF_FFFF);
    div_op("div minneg/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("div minneg lo const", lo_o, 32'h8000_0000);
    div_op("divu flushed", 1'b0, 32'd1000, 32'd3, 10);
    div_op("divu 9/3", 1'b0, 32'd9, 32'd3, -1);
`ifdef EX_MC_MULT_EN
    single("mult", 3'b100, 8'h18, 32'hFFFF_FFFE, 32'd3);
    chk("mult hi const", hi_o, 32'hFFFF_FFFF);
    chk("mult lo const", lo_o, 32'hFFFF_FFFA);
`else
    single("mult off", 3'b100, 8'h18, 32'hFFFF_FFFE, 32'd3);
`endif

    // Reset in the middle of a divide.
    drive(3'b100, 8'h1B, 32'd12345, 32'd11);
    repeat (5) begin @(posedge clk); #1; end
    chk("pre-rst stall", stall_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid rst stall", stall_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(3'b000, 8'h00, '0, '0);
    #1;
    m_hi = '0;
    m_lo = '0;
    chk("post rst stall", stall_o, 1'b0);
    chk("post rst hi", hi_o, '0);
    chk("post rst lo", lo_o, '0);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 19);
      a = $urandom;
      b = $urandom;
      if (ops[k] == 8'h1A || ops[k] == 8'h1B) begin
        if ($urandom_range(0, 3) == 0) b = '0;
        else b = b >> $urandom_range(0, 31);
        if ($urandom_range(0, 7) == 0) begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        div_op("rand div", ops[k] == 8'h1A, a, b, -1);
      end else begin
        s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : sels[k];
        single("rand op", s, ops[k], a, b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
